// File: rtl/snn_image_sequencer.sv
// snn_image_sequencer: fetches packed images from an external store and replays them
// REPEAT times per class into the classifier, counting completed images in epoch.
module snn_image_sequencer #(
   parameter  int M            = 784,
   parameter  int PIX_W        = 8,
   parameter  int PIX_PER_WORD = 4,
   parameter  int N_CLASS      = 4,
   parameter  int REPEAT       = 2500,
   parameter  int GAP          = 4,
   parameter  int TIMEOUT      = 65535,
   parameter  int ADDR_W       = 16,
   localparam int WORD_W       = PIX_W * PIX_PER_WORD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go,
   input  logic              abort,
   input  logic [1:0]        mode,
   input  logic              core_ready,
   input  logic              valid_all,
   output logic              img_rd_en,
   output logic [ADDR_W-1:0] img_addr,
   input  logic [WORD_W-1:0] img_rdata,
   output logic              start_main,
   output logic [WORD_W-1:0] image_in,
   output logic              valid_image,
   output logic [1:0]        train_test_classify,
   output logic [7:0]        test_label,
   output logic [31:0]       epoch,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int WORDS = M / PIX_PER_WORD;
   localparam int IW    = $clog2(WORDS + 1);
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int GW    = $clog2(GAP + 1);
   localparam int RW    = $clog2(REPEAT + 1);
   localparam int CW    = $clog2(N_CLASS + 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] G_LAST   = GW'(GAP - 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT - 1);
   localparam logic [CW-1:0] CLS_LAST = CW'(N_CLASS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_WAIT, S_GAP, S_DONE} state_t;
   state_t state, nxt;

   logic [IW-1:0] widx;
   logic [TW-1:0] tcnt;
   logic [GW-1:0] gcnt;
   logic [RW-1:0] rep;
   logic [CW-1:0] cls;
   logic          last_img, gap_end;

   assign last_img   = rep == REP_LAST && cls == CLS_LAST;
   assign gap_end    = gcnt == G_LAST;
   assign test_label = 8'(cls);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:   nxt = go ? S_START : S_IDLE;
         S_START:  nxt = core_ready ? S_STREAM : S_START;
         S_STREAM: nxt = img_rd_en ? S_STREAM : S_WAIT;
         S_WAIT:   nxt = valid_all ? S_GAP : (tcnt == T_LAST ? S_DONE : S_WAIT);
         S_GAP:    nxt = !gap_end ? S_GAP : (last_img ? S_DONE : S_START);
         S_DONE:   nxt = S_IDLE;
         default:  nxt = S_IDLE;
      endcase
      if (abort) nxt = S_IDLE;
   end

   // The stream stops once the read strobe has dropped; valid_image trails img_rd_en by one cycle.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         img_rd_en           <= 1'b0;
         img_addr            <= '0;
         start_main          <= 1'b0;
         image_in            <= '0;
         valid_image         <= 1'b0;
         train_test_classify <= 2'b00;
         epoch               <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         err                 <= 1'b0;
         widx                <= '0;
         tcnt                <= '0;
         gcnt                <= '0;
         rep                 <= '0;
         cls                 <= '0;
      end else begin
         start_main  <= 1'b0;
         img_rd_en   <= 1'b0;
         valid_image <= img_rd_en && !abort;
         image_in    <= img_rd_en ? img_rdata : image_in;
         done        <= nxt == S_DONE;
         busy        <= nxt != S_IDLE && nxt != S_DONE;
         if (!abort)
            case (state)
               S_IDLE:
                  if (go) begin
                     train_test_classify <= mode;
                     epoch               <= '0;
                     err                 <= 1'b0;
                     rep                 <= '0;
                     cls                 <= '0;
                  end
               S_START:
                  if (core_ready) begin
                     start_main <= 1'b1;
                     img_rd_en  <= 1'b1;
                     img_addr   <= ADDR_W'(int'(cls) * WORDS);
                     widx       <= IW'(1);
                  end
               S_STREAM: begin
                  tcnt <= '0;
                  if (widx != IW'(WORDS)) begin
                     img_rd_en <= 1'b1;
                     img_addr  <= img_addr + ADDR_W'(1);
                     widx      <= widx + IW'(1);
                  end
               end
               S_WAIT: begin
                  tcnt  <= tcnt + TW'(1);
                  gcnt  <= '0;
                  epoch <= valid_all ? epoch + 32'd1 : epoch;
                  err   <= err | (!valid_all && tcnt == T_LAST);
               end
               S_GAP: begin
                  gcnt <= gcnt + GW'(1);
                  if (gap_end) begin
                     rep <= rep == REP_LAST ? '0 : rep + RW'(1);
                     if (rep == REP_LAST) cls <= cls == CLS_LAST ? '0 : cls + CW'(1);
                  end
               end
               default: ;
            endcase
      end
endmodule

// File: tb/tb_snn_image_sequencer.sv
// tb_snn_image_sequencer: directed checks of run sequencing, timeout, abort, ready stalls
// and asynchronous reset; the image store answers {16'hC0DE, addr} combinationally.
module tb_snn_image_sequencer;
   localparam int ADDR_W = 16, WORD_W = 32;

   logic clk = 1'b0, rst_n = 1'b0, go = 1'b0, abort = 1'b0, core_ready = 1'b1, valid_all = 1'b0;
   logic [1:0] mode = 2'b00;
   logic img_rd_en, start_main, valid_image, busy, done, err;
   logic [ADDR_W-1:0] img_addr;
   logic [WORD_W-1:0] img_rdata, image_in;
   logic [1:0] ttc;
   logic [7:0] test_label;
   logic [31:0] epoch;

   snn_image_sequencer #(
      .M(16), .PIX_W(8), .PIX_PER_WORD(4), .N_CLASS(2), .REPEAT(3), .GAP(4), .TIMEOUT(50), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .abort(abort), .mode(mode), .core_ready(core_ready),
      .valid_all(valid_all), .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rdata(img_rdata),
      .start_main(start_main), .image_in(image_in), .valid_image(valid_image),
      .train_test_classify(ttc), .test_label(test_label), .epoch(epoch),
      .busy(busy), .done(done), .err(err)
   );

   assign img_rdata = {16'hC0DE, img_addr};
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor logs DUT activity at the falling edge; it also plays the classifier, answering
   // valid_all 8 cycles after each image (resp_en) and optionally adding pulses that must be ignored.
   int starts = 0, dones = 0, start_cyc = 0, fall_cyc = 0, err_rise = 0, wcnt = 0;
   bit resp_en = 1'b1, noisy = 1'b0, prev_vi = 1'b0, prev_err = 1'b0;
   logic [ADDR_W-1:0] addr_log[$];
   logic [WORD_W-1:0] data_log[$];
   logic [7:0] label_log[$];

   initial forever begin
      @(negedge clk);
      if (start_main) begin
         starts++;
         start_cyc = cyc;
         label_log.push_back(test_label);
      end
      if (img_rd_en) addr_log.push_back(img_addr);
      if (valid_image) data_log.push_back(image_in);
      if (done) dones++;
      if (err && !prev_err) err_rise = cyc;
      if (prev_vi && !valid_image) begin
         fall_cyc = cyc;
         wcnt = 1;
      end else if (wcnt > 0) wcnt++;
      valid_all = (resp_en && wcnt == 9) || (noisy && (valid_image || wcnt == 11));
      if (wcnt >= 11) wcnt = 0;
      prev_vi = valid_image;
      prev_err = err;
   end

   int n_cmp = 0, n_bad = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_go(input logic [1:0] m);
      mode = m;
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int lim);
      int d0 = dones;
      int k = 0;
      while (dones == d0 && k < lim) begin
         tick();
         k++;
      end
      check(tag, 32'(dones - d0), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int bs, ba, bd, bl, bdone, e, k, n;

   initial begin
      tick(2);
      check("rst_busy", 32'(busy), 0);
      check("rst_epoch", epoch, 0);
      check("rst_err_done", {err, done, start_main, valid_image, img_rd_en}, 0);
      check("rst_addr_label", {img_addr, test_label}, 0);
      rst_n = 1'b1;
      tick();

      // Full run: 2 classes x 3 reps, addresses 0..3 then 4..7, data = addr with 1-cycle lag
      bs = starts; ba = addr_log.size(); bd = data_log.size(); bl = label_log.size(); bdone = dones;
      pulse_go(2'b10);
      check("busy_after_go", 32'(busy), 1);
      tick();
      check("first_start", {start_main, img_rd_en, valid_image}, 3'b110);
      check("first_addr", 32'(img_addr), 0);
      tick();
      check("first_word", {start_main, valid_image}, 2'b01);
      check("first_data", image_in, 32'hC0DE0000);
      wait_done("run1_done", 2000);
      check("done_pulse", {done, busy}, 2'b10);
      check("run1_epoch", epoch, 6);
      check("run1_mode", 32'(ttc), 2);
      check("run1_starts", 32'(starts - bs), 6);
      check("run1_nwords", 32'(addr_log.size() - ba), 24);
      for (int i = 0; i < 6; i++) begin
         check("label", 32'(label_log[bl + i]), 32'(i / 3));
         for (int w = 0; w < 4; w++) begin
            e = (i / 3) * 4 + w;
            check("addr", 32'(addr_log[ba + i * 4 + w]), 32'(e));
            check("data", data_log[bd + i * 4 + w], {16'hC0DE, 16'(e)});
         end
      end
      tick();
      check("done_one_cycle", {done, busy, err}, 0);
      check("epoch_hold", epoch, 6);

      // Timeout: no valid_all, err exactly 50 cycles into WAIT
      resp_en = 1'b0;
      bs = starts;
      pulse_go(2'b01);
      check("t3_epoch_clear", epoch, 0);
      wait_done("t3_done", 300);
      check("t3_err", 32'(err), 1);
      check("t3_err_delay", 32'(err_rise - fall_cyc), 50);
      check("t3_busy", 32'(busy), 0);
      check("t3_epoch", epoch, 0);
      check("t3_starts", 32'(starts - bs), 1);
      tick(3);
      check("t3_err_sticky", {err, done}, 2'b10);
      resp_en = 1'b1;

      // valid_all pulses during STREAM and GAP must not count
      noisy = 1'b1;
      pulse_go(2'b00);
      check("t4_err_clear", 32'(err), 0);
      wait_done("t4_done", 2000);
      check("t4_epoch", epoch, 6);
      noisy = 1'b0;
      tick(2);

      // abort together with go in IDLE stays in IDLE
      go = 1'b1;
      abort = 1'b1;
      tick();
      go = 1'b0;
      abort = 1'b0;
      check("abort_go_idle", 32'(busy), 0);
      tick();
      check("abort_go_nostart", {busy, start_main, img_rd_en}, 0);

      // abort in the middle of image 2's stream
      bs = starts; bd = data_log.size(); bdone = dones;
      pulse_go(2'b11);
      k = 0;
      while (!(starts - bs == 2 && data_log.size() - bd == 6) && k < 500) begin
         tick();
         k++;
      end
      check("t5_midstream", 32'(valid_image), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_outputs", {valid_image, img_rd_en, start_main, busy}, 0);
      check("t5_epoch", epoch, 1);
      tick(10);
      check("t5_no_done", 32'(dones - bdone), 0);

      // restart, then hold core_ready low at the start of image 3
      bs = starts; bd = data_log.size();
      pulse_go(2'b01);
      check("t6_epoch_clear", epoch, 0);
      tick();
      check("t6_restart", {start_main, img_addr}, {1'b1, 16'd0});
      k = 0;
      while (!(starts - bs == 2 && data_log.size() - bd == 8 && !valid_image) && k < 500) begin
         tick();
         k++;
      end
      core_ready = 1'b0;
      tick(20);
      check("t6_start_held", 32'(starts - bs), 2);
      check("t6_busy_hold", 32'(busy), 1);
      n = cyc;
      core_ready = 1'b1;
      tick();
      check("t6_start_fire", 32'(start_main), 1);
      check("t6_start_cyc", 32'(start_cyc - n), 1);
      k = 0;
      while (!(data_log.size() - bd == 12 && !valid_image) && k < 500) begin
         tick();
         k++;
      end
      tick(3);
      check("t6_epoch_wait", epoch, 2);
      check("t6_mode", 32'(ttc), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_ctrl", {busy, done, err, start_main, valid_image, img_rd_en}, 0);
      check("t6_rst_epoch", epoch, 0);
      check("t6_rst_regs", {img_addr, test_label, 6'd0, ttc}, 0);
      check("t6_rst_image", image_in, 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("t6_idle_after_rst", {busy, start_main}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
